// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan test sequencing controller.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SHIFT,
        ST_CAPTURE,
        ST_FLUSH,
        ST_UNLOAD,
        ST_DONE
    } state_e;

    // {se1,se0} scan mode encodings
    localparam logic [1:0] MODE_CAP   = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;

    // x^8+x^6+x^5+x^4+1, right-shifting Fibonacci: tap k sits at bit 8-k
    localparam logic [7:0] LFSR_TAPS = 8'h1D;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {^(cur & LFSR_TAPS), cur[7:1]};
    endfunction

endpackage

// File: rtl/scan_test_ctrl_if.sv
// Bundle between the scan controller (master) and its environment/scan top (slave).
interface scan_test_ctrl_if #(
    parameter int unsigned SIG_W = 4
);
    logic             start;
    logic [1:0]       sig_sel;
    logic [SIG_W-1:0] golden;
    logic             sg0;
    logic             sci;
    logic             se0;
    logic             se1;
    logic             lck;
    logic             sge;
    logic             scj0;
    logic             scj1;
    logic             cs;
    logic             trg;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig_word;

    modport master (
        input  start, sig_sel, golden, sg0,
        output sci, se0, se1, lck, sge, scj0, scj1, cs, trg, busy, done, pass, sig_word
    );

    modport slave (
        output start, sig_sel, golden, sg0,
        input  sci, se0, se1, lck, sge, scj0, scj1, cs, trg, busy, done, pass, sig_word
    );
endinterface

// File: rtl/scan_lfsr8.sv
// 8-bit Fibonacci pattern LFSR with synchronous seed load and step enable.
module scan_lfsr8
    import scan_ctrl_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (advance) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: seeds/shifts LFSR patterns, captures, flushes, unloads
// the compacted signature and compares it against a latched golden value.
module scan_test_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned PATTERNS  = 8,
    parameter int unsigned SIG_W     = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               Clk,
    input  logic               reset,
    scan_test_ctrl_if.master   bus
);

    state_e           state_q, state_d;
    logic [7:0]       bit_q, bit_d;
    logic [7:0]       pat_q, pat_d;
    logic [1:0]       sig_sel_q, sig_sel_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [SIG_W-1:0] sig_word_q, sig_word_d;
    logic [1:0]       mode_q, mode_d;
    logic             lck_q, lck_d;
    logic             sge_q, sge_d;
    logic             sci_q, sci_d;
    logic             cs_q, cs_d;
    logic             trg_q, trg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       lfsr;
    logic             lfsr_load;
    logic             lfsr_adv;

    // The LFSR is held at the seed while idle and steps on every edge that
    // registers a new sci bit, so sci_q is always the bit for the current
    // SHIFT cycle without needing a look-ahead of the LFSR.
    assign lfsr_load = (state_q == ST_IDLE);
    assign lfsr_adv  = (state_d == ST_SHIFT);

    scan_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk     (Clk),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .q       (lfsr)
    );

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        pat_d      = pat_q;
        sig_sel_d  = sig_sel_q;
        golden_d   = golden_q;
        sig_word_d = sig_word_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SEED;
                    sig_sel_d = bus.sig_sel;
                    golden_d  = bus.golden;
                    bit_d     = '0;
                    pat_d     = '0;
                end
            end
            ST_SEED: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (bit_q == 8'(CHAIN_LEN - 1)) begin
                    state_d = ST_CAPTURE;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 8'd1;
                end
            end
            ST_CAPTURE: begin
                pat_d   = pat_q + 8'd1;
                state_d = (pat_d == 8'(PATTERNS)) ? ST_FLUSH : ST_SHIFT;
            end
            ST_FLUSH: begin
                if (bit_q == 8'(CHAIN_LEN - 1)) begin
                    state_d = ST_UNLOAD;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 8'd1;
                end
            end
            ST_UNLOAD: begin
                sig_word_d = SIG_W'({sig_word_q, bus.sg0});
                if (bit_q == 8'(SIG_W - 1)) begin
                    state_d = ST_DONE;
                    bit_d   = '0;
                end else begin
                    bit_d = bit_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered.
    always_comb begin
        mode_d = MODE_HOLD;
        lck_d  = 1'b0;
        sge_d  = 1'b0;
        sci_d  = 1'b0;
        cs_d   = (state_d != ST_IDLE);
        trg_d  = (state_q == ST_IDLE) && bus.start;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (sig_word_d == golden_d);
        case (state_d)
            ST_SHIFT: begin
                mode_d = MODE_SHIFT;
                lck_d  = 1'b1;
                sge_d  = 1'b1;
                sci_d  = lfsr[0];
            end
            ST_CAPTURE: begin
                mode_d = MODE_CAP;
                lck_d  = 1'b1;
            end
            ST_FLUSH: begin
                mode_d = MODE_SHIFT;
                lck_d  = 1'b1;
                sge_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            pat_q      <= '0;
            sig_sel_q  <= '0;
            golden_q   <= '0;
            sig_word_q <= '0;
            mode_q     <= MODE_HOLD;
            lck_q      <= 1'b0;
            sge_q      <= 1'b0;
            sci_q      <= 1'b0;
            cs_q       <= 1'b0;
            trg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            pat_q      <= pat_d;
            sig_sel_q  <= sig_sel_d;
            golden_q   <= golden_d;
            sig_word_q <= sig_word_d;
            mode_q     <= mode_d;
            lck_q      <= lck_d;
            sge_q      <= sge_d;
            sci_q      <= sci_d;
            cs_q       <= cs_d;
            trg_q      <= trg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.sci      = sci_q;
    assign bus.se0      = mode_q[0];
    assign bus.se1      = mode_q[1];
    assign bus.lck      = lck_q;
    assign bus.sge      = sge_q;
    assign bus.scj0     = sig_sel_q[0];
    assign bus.scj1     = sig_sel_q[1];
    assign bus.cs       = cs_q;
    assign bus.trg      = trg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.sig_word = sig_word_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Scoreboard bench: dut_a uses default parameters, dut_b a 4-bit chain with 2 patterns.
module tb_scan_test_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    typedef struct packed {
        logic [1:0] mode;
        logic       lck;
        logic       sge;
        logic       sci;
        logic       trg;
        logic       busy;
        logic       done;
        logic [1:0] scj;
        logic       last;
        logic       pass;
        logic [3:0] sig;
    } exp_t;

    exp_t qb[$];
    logic qa[$];

    scan_test_ctrl_if #(.SIG_W(4)) ifa ();
    scan_test_ctrl_if #(.SIG_W(4)) ifb ();

    scan_test_ctrl dut_a (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (ifa)
    );

    scan_test_ctrl #(
        .CHAIN_LEN (4),
        .PATTERNS  (2),
        .SIG_W     (4),
        .LFSR_SEED (8'hA5)
    ) dut_b (
        .Clk   (clk),
        .reset (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] mode, input logic lck, input logic sge,
                                input logic sci, input logic trg, input logic busy,
                                input logic done, input logic [1:0] scj, input logic last,
                                input logic pass, input logic [3:0] sig);
        exp_t e;
        e.mode = mode; e.lck = lck; e.sge = sge; e.sci = sci; e.trg = trg;
        e.busy = busy; e.done = done; e.scj = scj; e.last = last; e.pass = pass; e.sig = sig;
        return e;
    endfunction

    // {sci,se1,se0,lck,sge,cs,trg,busy,done,pass,scj1,scj0}
    function automatic logic [11:0] a_outs();
        return {ifa.sci, ifa.se1, ifa.se0, ifa.lck, ifa.sge, ifa.cs, ifa.trg,
                ifa.busy, ifa.done, ifa.pass, ifa.scj1, ifa.scj0};
    endfunction

    // dut_b monitor: one expected entry per non-idle cycle
    always @(negedge clk) begin
        if (ifb.cs === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_cycle: got cs=1 with no expected entry, required idle at %0t", $time);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_cycle_outputs",
                    {ifb.se1, ifb.se0, ifb.lck, ifb.sge, ifb.sci, ifb.trg, ifb.busy, ifb.done, ifb.scj1, ifb.scj0},
                    {e.mode, e.lck, e.sge, e.sci, e.trg, e.busy, e.done, e.scj});
                if (e.last) begin
                    chk("b_sig_word", ifb.sig_word, e.sig);
                    chk("b_pass", ifb.pass, e.pass);
                end
            end
        end
    end

    // dut_a monitor: expected sci bits for shift-mode cycles while armed
    always @(negedge clk) begin
        if (ifa.se1 === 1'b0 && ifa.se0 === 1'b1 && qa.size() > 0) begin
            logic b;
            b = qa.pop_front();
            chk("a_sci_stream", ifa.sci, b);
        end
    end

    task automatic push_b_run(input logic [1:0] sel, input logic pass_e, input logic [3:0] sig_e);
        logic [7:0] stream;
        stream = 8'hA5;
        qb.push_back(mk(2'b10, 0, 0, 0, 1, 1, 0, sel, 0, 0, 4'h0));
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++)
                qb.push_back(mk(2'b01, 1, 1, stream[p*4+i], 0, 1, 0, sel, 0, 0, 4'h0));
            qb.push_back(mk(2'b00, 1, 0, 0, 0, 1, 0, sel, 0, 0, 4'h0));
        end
        for (int i = 0; i < 4; i++) qb.push_back(mk(2'b01, 1, 1, 0, 0, 1, 0, sel, 0, 0, 4'h0));
        for (int i = 0; i < 4; i++) qb.push_back(mk(2'b10, 0, 0, 0, 0, 1, 0, sel, 0, 0, 4'h0));
        qb.push_back(mk(2'b10, 0, 0, 0, 0, 0, 1, sel, 1, pass_e, sig_e));
    endtask

    task automatic run_b(input logic [1:0] sel, input logic [3:0] golden, input logic [3:0] sgbits,
                         input logic pass_e, input logic [3:0] sig_e, input logic change_sel);
        push_b_run(sel, pass_e, sig_e);
        @(negedge clk);
        ifb.start   = 1'b1;
        ifb.sig_sel = sel;
        ifb.golden  = golden;
        @(posedge clk);
        #1;
        ifb.start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            ifb.sg0 = (j >= 15 && j <= 18) ? sgbits[18-j] : 1'b0;
            if (change_sel && j == 5) begin
                ifb.sig_sel = ~sel;
                ifb.golden  = ~golden;
            end
            @(posedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        chk("b_queue_drained", qb.size(), 0);
    endtask

    task automatic push_a_stream();
        logic [15:0] s;
        s = 16'h72A5;
        for (int i = 0; i < 16; i++) qa.push_back(s[i]);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.sig_sel = 2'b00; ifa.golden = 4'h0; ifa.sg0 = 1'b0;
        ifb.start = 1'b0; ifb.sig_sel = 2'b00; ifb.golden = 4'h0; ifb.sg0 = 1'b0;
        #12;
        chk("a_reset_outputs", a_outs(), 12'h400);
        chk("a_reset_sig_word", ifa.sig_word, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_idle_no_change", a_outs(), 12'h400);
        end

        // dut_b: mode sequence, timing, unload, pass, latched sig_sel/golden
        run_b(2'b10, 4'hB, 4'b1011, 1'b1, 4'hB, 1'b1);
        run_b(2'b01, 4'hA, 4'b1011, 1'b0, 4'hB, 1'b0);

        // dut_a: sci stream, then reset during second SHIFT
        push_a_stream();
        @(negedge clk);
        ifa.start   = 1'b1;
        ifa.sig_sel = 2'b10;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("a_stream_consumed", qa.size(), 0);
        chk("a_midrun_busy", ifa.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_async_reset_outputs", a_outs(), 12'h400);
        chk("a_async_reset_sig_word", ifa.sig_word, 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ifa.sig_sel = 2'b00;
        ifa.golden  = 4'h0;
        ifa.sg0     = 1'b0;

        // fresh run with start held high: identical stream, full length, no retrigger
        push_a_stream();
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (ifa.done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("a_run_length", n, 157);
        chk("a_restart_stream_consumed", qa.size(), 0);
        chk("a_done_pass", {ifa.done, ifa.pass, ifa.busy}, 3'b110);
        chk("a_done_sig_word", ifa.sig_word, 4'h0);
        repeat (5) @(negedge clk);
        chk("a_held_start_stays_done", {ifa.done, ifa.busy, ifa.cs}, 3'b101);
        ifa.start = 1'b0;
        @(negedge clk);
        chk("a_back_to_idle", {ifa.done, ifa.cs}, 2'b00);
        repeat (5) @(negedge clk);
        chk("a_no_retrigger", {ifa.busy, ifa.cs, ifa.trg}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scan_test_ctrl.md
# scan_test_ctrl

Sequencing controller that sits directly upstream of the four-cluster reconfigurable scan top. It drives scan enables, cluster clock enable, signature enable, signature-register select, clock-source select and pulse trigger, and feeds the serial scan input from an internal LFSR pattern generator. After the run it unloads the compacted signature from the top's serial signature output and compares it against a golden value.

## Interface
- CHAIN_LEN, 16: shift cycles per pattern, i.e. the total scan length through all four clusters. Range 2..255.
- PATTERNS, 8: patterns applied per run. Range 1..255.
- SIG_W, 4: signature bits unloaded from sg0.
- LFSR_SEED, 8'hA5: non-zero reset/seed value of the 8-bit pattern LFSR.
- Clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled in IDLE only.
- sig_sel  in  2  signature register to compact into, latched at start.
- golden  in  SIG_W  expected signature, latched at start.
- sg0  in  1  serial signature output of the scan top.
- sci  out  1  serial scan data into the first cluster.
- se0, se1  out  1 each  scan mode: {se1,se0}=00 capture, 01 shift, 10 hold; 11 is never driven.
- lck  out  1  cluster clock enable.
- sge  out  1  signature compaction enable.
- scj0, scj1  out  1 each  signature register select = latched sig_sel (scj0 = LSB).
- cs  out  1  clock-source select to the top; 1 in every non-IDLE state.
- trg  out  1  one-cycle pulse-generator trigger.
- busy, done, pass  out  1 each  status.
- sig_word  out  SIG_W  unloaded signature.

## Operation
- States: IDLE, SEED, SHIFT, CAPTURE, FLUSH, UNLOAD, DONE.
- IDLE: start=1 latches sig_sel and golden, clears pattern and bit counters, and pulses trg for one cycle. Next state SEED.
- SEED (1 cycle): LFSR <= LFSR_SEED. {se1,se0}=10, lck=0. Next state SHIFT.
- SHIFT (CHAIN_LEN cycles): {se1,se0}=01, lck=1, sge=1, sci=LFSR[0]. LFSR advances each cycle with polynomial x^8+x^6+x^5+x^4+1, Fibonacci, shifting right. Next state CAPTURE.
- CAPTURE (1 cycle): {se1,se0}=00, lck=1, sge=0, sci=0. Pattern count increments. If count==PATTERNS go to FLUSH, else go to SHIFT.
- FLUSH (CHAIN_LEN cycles): as SHIFT but sci=0 and the LFSR is frozen; this compacts the last response. Next state UNLOAD.
- UNLOAD (SIG_W cycles): {se1,se0}=10, lck=0, sge=0. sig_word <= {sig_word[SIG_W-2:0], sg0}, MSB first. Next state DONE.
- DONE: done=1, pass=(sig_word==golden). Hold until start=0, then go to IDLE. A held start does not retrigger.
- busy=1 in SEED..UNLOAD.
- Bit counter is 8 bits and wraps to 0 on each state exit. Pattern counter is 8 bits.
- start outside IDLE is ignored.

## Timing
- Reset values:
  - sci, se0, lck, sge, cs, trg, busy, done, pass: 0
  - se1: 1 (hold)
  - scj0, scj1: 0
  - sig_word: 0
  - LFSR: LFSR_SEED
  - state: IDLE
- All outputs are registered, with no combinational path from input to output.
- trg is high in the cycle after start is sampled. SEED occupies that same cycle.
- Run length from the start-sample edge to the first done=1 cycle: 1 + PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + SIG_W cycles.
- sg0 is sampled on the edge ending each UNLOAD cycle.
- pass is valid in the same cycle done first rises.
- reset asserted mid-run forces reset values immediately. No partial signature is retained.

## Structure
- Package scan_ctrl_pkg holds:
  - the state enum
  - the {se1,se0} mode encodings MODE_CAP, MODE_SHIFT, MODE_HOLD
  - the LFSR tap mask
- Sub-module scan_lfsr8 (load, advance, q) is natural. The FSM, counters and unload shifter stay in scan_test_ctrl.

## Test plan
- Reset with default parameters: all outputs at their reset values, se1=1, state IDLE. start held low for 10 cycles produces no change.
- CHAIN_LEN=4, PATTERNS=2, SIG_W=4: after start, trg pulses once; mode sequence is 10, 01×4, 00, 01×4, 00, 01×4, 10×4; done rises 19 cycles after the start sample.
- SHIFT sci stream: first 8 bits are 1,0,1,0,0,1,0,1, which are the LSB-first bits of 8'hA5. The ninth bit matches the polynomial model. sci is 0 throughout FLUSH.
- sg0 driven 1,0,1,1 in UNLOAD with golden=4'hB: sig_word=4'hB and pass=1. With golden=4'hA: pass=0.
- sig_sel=2'b10: scj1=1 and scj0=0 for the whole run. A mid-run change of sig_sel has no effect.
- reset pulsed low during the second SHIFT: outputs return to reset values asynchronously. A fresh start repeats the identical sci stream. start held high through DONE does not restart until it drops.
